// File: rtl/uart_rx15_pkg.sv
// Shared types and constants for the uart_rx15 receive engine.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: FSM state enum, FIFO word struct, default oversample constants
// and helpers that derive the tick-counter geometry from an oversample ratio.
package uart_rx_pkg15;

   localparam int MAX_DATA_BITS  = 8;
   localparam int DEF_OVERSAMPLE = 16;

   function automatic int cnt_width(input int os);
      return $clog2(os);
   endfunction

   function automatic int mid_tick(input int os);
      return os / 2 - 1;
   endfunction

   localparam int CNT_W    = cnt_width(DEF_OVERSAMPLE);
   localparam int MID_TICK = mid_tick(DEF_OVERSAMPLE);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BRK_WAIT
   } rx_state_e;

   // Data is sized for the widest legal frame; narrower frames use the low bits.
   typedef struct packed {
      logic [MAX_DATA_BITS-1:0] data;
      logic                     perr;
      logic                     ferr;
   } rx_word_t;

endpackage

// File: rtl/uart_rx15_fifo.sv
// Synchronous FIFO holding received words for the host side.
// Latency: a push is visible at the head (empty deasserts) the cycle after the write edge.
// Backpressure: a push on a full FIFO is dropped unless a pop happens in the same cycle.
// Ports: clock15/reset (async active-low), push/wdat write side, pop/rdat read side,
//        full/empty/count status (count is occupancy, log2(DEPTH)+1 bits).
module uart_rx_fifo15
   import uart_rx_pkg15::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clock15,
   input  logic                       reset,
   input  logic                       push,
   input  rx_word_t                   wdat,
   input  logic                       pop,
   output rx_word_t                   rdat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;

   rx_word_t          mem [DEPTH];
   logic [AW:0]       wp;
   logic [AW:0]       rp;
   logic              wr;
   logic              rd;

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign wr    = push && (!full || pop);
   assign rd    = pop && !empty;
   assign count = wp - rp;
   assign full  = (count == CNTW'(DEPTH));
   assign empty = (wp == rp);
   assign rdat  = mem[rp[AW-1:0]];

   always_ff @(posedge clock15 or negedge reset) begin
      if (!reset) begin
         wp <= '0;
         rp <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr) begin
            mem[wp[AW-1:0]] <= wdat;
            wp              <= wp + 1'b1;
         end
         if (rd) begin
            rp <= rp + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_rx15.sv
// UART receiver: 2-flop sync, 16x oversampled LSB-first deframer, parity/stop check, RX FIFO.
// Latency: word reaches the FIFO head one clock after its stop-bit sample.
// Backpressure: rx_valid/rx_ready pop; full FIFO drops new words (sticky overrun), rts_n15 warns peer.
// Ports: clock15/reset (async active-low); rxd15 serial in, baud_clk15 oversample enable;
//        parity_en/parity_odd frame format; rx_data/rx_perr/rx_ferr/rx_valid/rx_ready host side;
//        overrun/ovr_clr, break_det pulse, rts_n15 flow control.
module uart_rx15
   import uart_rx_pkg15::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic                 clock15,
   input  logic                 reset,
   input  logic                 rxd15,
   input  logic                 baud_clk15,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_perr,
   output logic                 rx_ferr,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 overrun,
   input  logic                 ovr_clr,
   output logic                 break_det,
   output logic                 rts_n15
);

   localparam int TW   = cnt_width(OVERSAMPLE);
   localparam int IW   = $clog2(DATA_BITS);
   localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [TW-1:0] MID  = TW'(mid_tick(OVERSAMPLE));
   localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

   logic                 sync1;
   logic                 rs;
   rx_state_e            state;
   logic [TW-1:0]        tick_cnt;
   logic [IW-1:0]        bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 pen_l;
   logic                 podd_l;
   logic                 perr_l;
   logic                 pbit_l;

   logic                 sample;
   logic                 stop_smp;
   logic                 is_break;
   logic                 push;
   logic                 pop;
   rx_word_t             push_word;
   rx_word_t             head_word;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNTW-1:0]      fifo_count;

   // rxd15 is asynchronous; idle-high reset keeps the FSM from seeing a false start.
   always_ff @(posedge clock15 or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b1;
         rs    <= 1'b1;
      end else begin
         sync1 <= rxd15;
         rs    <= sync1;
      end
   end

   // Tick counter wraps at OVERSAMPLE, so LAST falls exactly one bit time after each sample.
   assign sample   = baud_clk15 && (tick_cnt == LAST);
   assign stop_smp = (state == STOP) && sample;
   // Break: whole frame low, including parity (pbit_l stays 0 when parity is off) and stop.
   assign is_break = stop_smp && !rs && (shift == '0) && !pbit_l;
   assign push     = stop_smp && !is_break;
   assign pop      = rx_valid && rx_ready;

   always_comb begin
      push_word                      = '0;
      push_word.data[DATA_BITS-1:0]  = shift;
      push_word.perr                 = perr_l;
      push_word.ferr                 = ~rs;
   end

   always_ff @(posedge clock15 or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         pen_l     <= 1'b0;
         podd_l    <= 1'b0;
         perr_l    <= 1'b0;
         pbit_l    <= 1'b0;
         break_det <= 1'b0;
      end else begin
         break_det <= 1'b0;
         // Everything is gated by the baud enable so a stalled baud generator freezes the FSM.
         if (baud_clk15) begin
            tick_cnt <= tick_cnt + 1'b1;
            case (state)
               IDLE: begin
                  if (!rs) begin
                     state    <= START;
                     tick_cnt <= '0;
                  end
               end
               START: begin
                  if (tick_cnt == MID) begin
                     if (rs) begin
                        state <= IDLE;
                     end else begin
                        state    <= DATA;
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        pen_l    <= parity_en;
                        podd_l   <= parity_odd;
                        perr_l   <= 1'b0;
                        pbit_l   <= 1'b0;
                     end
                  end
               end
               DATA: begin
                  if (tick_cnt == LAST) begin
                     shift[bit_idx] <= rs;
                     if (bit_idx == IW'(DATA_BITS - 1)) begin
                        state <= pen_l ? PARITY : STOP;
                     end else begin
                        bit_idx <= bit_idx + 1'b1;
                     end
                  end
               end
               PARITY: begin
                  if (tick_cnt == LAST) begin
                     pbit_l <= rs;
                     perr_l <= (((^shift) ^ rs) != podd_l);
                     state  <= STOP;
                  end
               end
               STOP: begin
                  if (tick_cnt == LAST) begin
                     if (is_break) begin
                        break_det <= 1'b1;
                        state     <= BRK_WAIT;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
               BRK_WAIT: begin
                  if (rs) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   uart_rx_fifo15 #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock15 (clock15),
      .reset   (reset),
      .push    (push),
      .wdat    (push_word),
      .pop     (pop),
      .rdat    (head_word),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign rx_valid = !fifo_empty;
   assign rx_data  = head_word.data[DATA_BITS-1:0];
   assign rx_perr  = head_word.perr;
   assign rx_ferr  = head_word.ferr;

   // A same-cycle pop makes room, so only an unserviced push on full is an overrun.
   // Setting wins over ovr_clr so a coincident overrun is never lost.
   always_ff @(posedge clock15 or negedge reset) begin
      if (!reset) begin
         overrun <= 1'b0;
         rts_n15 <= 1'b0;
      end else begin
         if (push && fifo_full && !pop) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
         rts_n15 <= (fifo_count >= CNTW'(FIFO_DEPTH - 1));
      end
   end

endmodule

// File: tb/tb_uart_rx15.sv
// Self-checking bench for uart_rx15: serial frames driven bit by bit,
// expected words queued at drive time and compared as the DUT hands them over.
module tb_uart_rx15;

   localparam int OS = 16;

   logic       clock15    = 1'b0;
   logic       reset      = 1'b0;
   logic       rxd15      = 1'b1;
   logic       baud_clk15 = 1'b0;
   logic       parity_en  = 1'b0;
   logic       parity_odd = 1'b0;
   logic       rx_ready   = 1'b0;
   logic       ovr_clr    = 1'b0;
   logic [7:0] rx_data;
   logic       rx_perr;
   logic       rx_ferr;
   logic       rx_valid;
   logic       overrun;
   logic       break_det;
   logic       rts_n15;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         valid_cycles = 0;
   int         brk_pulses   = 0;
   logic [9:0] exp_q[$];

   uart_rx15 #(
      .DATA_BITS  (8),
      .FIFO_DEPTH (4),
      .OVERSAMPLE (OS)
   ) dut (
      .clock15    (clock15),
      .reset      (reset),
      .rxd15      (rxd15),
      .baud_clk15 (baud_clk15),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .rx_data    (rx_data),
      .rx_perr    (rx_perr),
      .rx_ferr    (rx_ferr),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .overrun    (overrun),
      .ovr_clr    (ovr_clr),
      .break_det  (break_det),
      .rts_n15    (rts_n15)
   );

   always #5 clock15 = ~clock15;

   // Baud enable: one-cycle pulse every second clock.
   initial begin
      forever begin
         @(posedge clock15);
         #1;
         baud_clk15 = !baud_clk15;
      end
   end

   // Scoreboard: every accepted head entry must match the oldest queued expectation.
   always @(negedge clock15) begin
      logic [9:0] exp_w;
      if (rx_valid) valid_cycles++;
      if (break_det) brk_pulses++;
      if (rx_valid && rx_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_word got data=%h perr=%b ferr=%b, none expected",
                     rx_data, rx_perr, rx_ferr);
         end else begin
            exp_w = exp_q.pop_front();
            if ({rx_data, rx_perr, rx_ferr} !== exp_w) begin
               n_fail++;
               $display("FAIL rx_word got data=%h perr=%b ferr=%b, want data=%h perr=%b ferr=%b",
                        rx_data, rx_perr, rx_ferr, exp_w[9:2], exp_w[1], exp_w[0]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Returns at posedge+1 after n baud ticks have been seen.
   task automatic wait_ticks(input int n);
      int k = 0;
      while (k < n) begin
         @(posedge clock15);
         if (baud_clk15) k++;
      end
      #1;
   endtask

   task automatic send_bit(input logic b);
      rxd15 = b;
      wait_ticks(OS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                             input logic pbit, input logic stopb, input bit expect_word);
      logic perr;
      perr = pen ? (((^d) ^ pbit) != podd) : 1'b0;
      if (expect_word) exp_q.push_back({d, perr, ~stopb});
      parity_en  = pen;
      parity_odd = podd;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (pen) send_bit(pbit);
      send_bit(stopb);
      rxd15 = 1'b1;
   endtask

   task automatic drain_check(input string name);
      int k = 0;
      while (exp_q.size() != 0 && k < 3000) begin
         @(negedge clock15);
         k++;
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain remaining=%0d, want 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      repeat (4) @(posedge clock15);
      @(negedge clock15);
      n_tests++; if (rx_valid  !== 1'b0)  begin n_fail++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
      n_tests++; if (rx_data   !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
      n_tests++; if (rx_perr   !== 1'b0)  begin n_fail++; $display("FAIL reset_rx_perr got=%b want=0", rx_perr); end
      n_tests++; if (rx_ferr   !== 1'b0)  begin n_fail++; $display("FAIL reset_rx_ferr got=%b want=0", rx_ferr); end
      n_tests++; if (overrun   !== 1'b0)  begin n_fail++; $display("FAIL reset_overrun got=%b want=0", overrun); end
      n_tests++; if (break_det !== 1'b0)  begin n_fail++; $display("FAIL reset_break_det got=%b want=0", break_det); end
      n_tests++; if (rts_n15   !== 1'b0)  begin n_fail++; $display("FAIL reset_rts_n15 got=%b want=0", rts_n15); end
      @(posedge clock15); #1;
      reset = 1'b1;
      wait_ticks(2 * OS);
   endtask

   task automatic test_8n1();
      int v0;
      rx_ready = 1'b1;
      v0 = valid_cycles;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      // The word must already be delivered by the end of the stop bit.
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL 8n1_latency pending=%0d at end of stop bit, want 0", exp_q.size());
      end
      wait_ticks(OS);
      drain_check("8n1");
      n_tests++;
      if (valid_cycles - v0 != 1) begin
         n_fail++; $display("FAIL 8n1_valid_width got=%0d cycles want=1", valid_cycles - v0);
      end
   endtask

   task automatic test_parity();
      logic [1:0] cases [4];
      cases[0] = 2'b00; cases[1] = 2'b01; cases[2] = 2'b10; cases[3] = 2'b11;
      rx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         // cases[i] = {parity_odd, parity bit}
         send_frame(8'h07, 1'b1, cases[i][1], cases[i][0], 1'b1, 1'b1);
         wait_ticks(OS);
         drain_check("parity");
      end
   endtask

   task automatic test_framing();
      int b0;
      rx_ready = 1'b1;
      b0 = brk_pulses;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_ticks(2 * OS);
      drain_check("framing");
      n_tests++;
      if (brk_pulses != b0) begin
         n_fail++; $display("FAIL framing_no_break got=%0d pulses want=0", brk_pulses - b0);
      end
   endtask

   task automatic test_break();
      int b0;
      int v0;
      rx_ready  = 1'b1;
      parity_en = 1'b0;
      b0 = brk_pulses;
      v0 = valid_cycles;
      rxd15 = 1'b0;
      wait_ticks(20 * OS);
      n_tests++;
      if (brk_pulses - b0 != 1) begin
         n_fail++; $display("FAIL break_pulse got=%0d pulses want=1", brk_pulses - b0);
      end
      n_tests++;
      if (valid_cycles != v0) begin
         n_fail++; $display("FAIL break_no_push got=%0d valid cycles want=0", valid_cycles - v0);
      end
      rxd15 = 1'b1;
      wait_ticks(2 * OS);
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_ticks(OS);
      drain_check("break_recover");
      n_tests++;
      if (brk_pulses - b0 != 1) begin
         n_fail++; $display("FAIL break_once got=%0d pulses want=1", brk_pulses - b0);
      end
   endtask

   task automatic test_overrun();
      rx_ready = 1'b0;
      for (int w = 1; w <= 5; w++) begin
         send_frame(8'(w), 1'b0, 1'b0, 1'b0, 1'b1, (w <= 4));
         wait_ticks(OS);
         if (w == 2) begin
            n_tests++;
            if (rts_n15 !== 1'b0) begin n_fail++; $display("FAIL rts_after_2 got=%b want=0", rts_n15); end
         end
         if (w == 3) begin
            n_tests++;
            if (rts_n15 !== 1'b1) begin n_fail++; $display("FAIL rts_after_3 got=%b want=1", rts_n15); end
         end
         if (w == 4) begin
            n_tests++;
            if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_after_4 got=%b want=0", overrun); end
         end
      end
      n_tests++;
      if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_after_5 got=%b want=1", overrun); end
      n_tests++;
      if (rx_data !== 8'h01) begin n_fail++; $display("FAIL head_stable got=%h want=01", rx_data); end
      rx_ready = 1'b1;
      drain_check("overrun");
      wait_ticks(4);
      n_tests++;
      if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky got=%b want=1", overrun); end
      n_tests++;
      if (rts_n15 !== 1'b0) begin n_fail++; $display("FAIL rts_after_drain got=%b want=0", rts_n15); end
      ovr_clr = 1'b1;
      @(posedge clock15); #1;
      ovr_clr = 1'b0;
      @(negedge clock15);
      n_tests++;
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear got=%b want=0", overrun); end
   endtask

   task automatic test_glitch();
      int v0;
      int b0;
      rx_ready = 1'b1;
      v0 = valid_cycles;
      b0 = brk_pulses;
      rxd15 = 1'b0;
      wait_ticks(6);
      rxd15 = 1'b1;
      wait_ticks(3 * OS);
      n_tests++;
      if (valid_cycles != v0 || brk_pulses != b0) begin
         n_fail++; $display("FAIL glitch_ignored got valid=%0d brk=%0d want 0 0",
                            valid_cycles - v0, brk_pulses - b0);
      end
      send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_ticks(OS);
      drain_check("glitch_recover");
   endtask

   task automatic test_reset_midframe();
      rx_ready = 1'b0;
      // Leave a word in the FIFO that the reset must discard.
      send_frame(8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      wait_ticks(OS);
      n_tests++;
      if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got=%b want=1", rx_valid); end
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      reset = 1'b0;
      rxd15 = 1'b1;
      @(negedge clock15);
      n_tests++;
      if ({rx_valid, rx_data, rx_perr, rx_ferr, overrun, break_det, rts_n15} !== 14'h0) begin
         n_fail++;
         $display("FAIL midframe_reset got valid=%b data=%h perr=%b ferr=%b ovr=%b brk=%b rts=%b want all 0",
                  rx_valid, rx_data, rx_perr, rx_ferr, overrun, break_det, rts_n15);
      end
      repeat (3) @(posedge clock15);
      #1;
      reset = 1'b1;
      wait_ticks(2 * OS);
      rx_ready = 1'b1;
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      wait_ticks(OS);
      drain_check("after_reset");
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_framing();
      test_break();
      test_overrun();
      test_glitch();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx15.md
Name: uart_rx15

Overview:
- UART receive engine, the far end of the serial link driven onto the txd15/rxd15 pins of uart_if15.
- Oversamples rxd15 using a 16x baud enable, deserialises LSB-first frames and checks parity and stop bit.
- Buffers received words in a small FIFO, presented to the host side on a valid/ready handshake.
- Drives rts_n15 for hardware flow control; sits in the UART DUT next to the transmitter and register block.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- FIFO_DEPTH, 4, receive buffer entries; power of two, minimum 2.
- OVERSAMPLE, 16, baud_clk15 pulses per bit time.

Ports:
- clock15  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rxd15  input  1  serial receive data, asynchronous to clock15; idles high.
- baud_clk15  input  1  one-cycle enable pulse at OVERSAMPLE x baud, synchronous to clock15.
- parity_en  input  1  1 = frame carries a parity bit.
- parity_odd  input  1  1 = odd parity, 0 = even parity.
- rx_data  output  DATA_BITS  head-of-FIFO data.
- rx_perr  output  1  parity error flag of the head entry.
- rx_ferr  output  1  framing error flag of the head entry.
- rx_valid  output  1  head entry available.
- rx_ready  input  1  consumer accepts the head entry.
- overrun  output  1  sticky; set when a word arrives while the FIFO is full.
- ovr_clr  input  1  clears overrun.
- break_det  output  1  one-cycle pulse on break detection.
- rts_n15  output  1  0 = peer may send.

Behaviour:
- Reset values: rx_data=0, rx_perr=0, rx_ferr=0, rx_valid=0, overrun=0, break_det=0, rts_n15=0, FSM=IDLE, FIFO empty.
- Sync registers reset to 1.
- rxd15 passes through a 2-flop synchroniser; all further references use the synchronised value rs.
- Tick counter (log2 OVERSAMPLE bits) advances only on baud_clk15.
- FSM states and transitions:
  - IDLE: rs==0 -> START, counter=0.
  - START: at the tick where counter==OVERSAMPLE/2-1 (mid-bit), sample rs. If rs==1, treat as a glitch -> IDLE, nothing recorded. Otherwise -> DATA, counter=0, bit index=0.
  - DATA: sample rs when counter==OVERSAMPLE-1 (one bit time after the previous sample) into shift bit[index], LSB first. After DATA_BITS samples -> PARITY if parity_en, else STOP.
  - PARITY: sample on the same timing. perr = (XOR of data bits ^ sampled bit) != parity_odd.
  - STOP: sample on the same timing. ferr = (sample==0). Push the word.
    - If data, parity and stop are all 0: pulse break_det, push nothing, -> BRK_WAIT.
    - Otherwise -> IDLE.
  - BRK_WAIT: wait for rs==1, then -> IDLE.
- parity_en and parity_odd are sampled at the START->DATA transition; changes mid-frame have no effect.
- Push timing: the word is written in the cycle of the stop sample. With the FIFO empty, rx_valid rises on the next clock15 edge.
- Handshake:
  - Pop occurs when rx_valid && rx_ready.
  - rx_data, rx_perr and rx_ferr stay stable while rx_valid && !rx_ready.
  - Push and pop in the same cycle on a full FIFO: both take effect, no overrun.
- Overrun: a push on a full FIFO with no pop drops the new word and sets overrun. overrun holds until ovr_clr; if ovr_clr and a new overrun coincide, overrun stays set.
- Flow control: rts_n15 = 1 when FIFO occupancy >= FIFO_DEPTH-1, else 0; registered.
- FIFO read and write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- Reset asserted mid-frame: everything returns to reset values immediately and the partial frame is lost.
- baud_clk15 held low: FSM freezes in its current state.

Decomposition:
- Package uart_rx_pkg15 holds:
  - state enum rx_state_e {IDLE, START, DATA, PARITY, STOP, BRK_WAIT};
  - struct rx_word_t {data, perr, ferr};
  - localparams for the mid-bit tick and the counter width.
- Sub-module uart_rx_fifo15: synchronous FIFO of rx_word_t with push/pop/full/empty/count outputs.
- FSM and synchroniser live in the top module.

Test Plan:
- 8N1 frame 0xA5, parity_en=0, rx_ready=1 -> rx_valid for one cycle, rx_data=0xA5, perr=0, ferr=0; rx_valid rises one cycle after the stop sample.
- Even parity, data 0x07 sent with parity bit 0 -> rx_perr=1. Same frame with parity bit 1 -> rx_perr=0. parity_odd=1 with parity bit 0 -> rx_perr=0.
- 0x3C with stop bit driven 0 followed by idle high -> rx_ferr=1 with rx_data=0x3C. A separate 20-bit-time low with parity_en=0 -> break_det pulses once, no FIFO push, FSM waits for high.
- rx_ready=0, send 5 words 0x01..0x05 -> rts_n15=1 after the 3rd word, overrun=1 after the 5th. Draining yields 0x01..0x04; ovr_clr drops overrun.
- 6-tick low glitch on rxd15 -> no word pushed, FSM back in IDLE. Reset asserted during DATA of a frame -> all outputs at reset values, next clean frame 0x5A received correctly.
